// File: rtl/tick_phase_sequencer_pkg.sv
// Shared definitions for the tick-driven phase sequencer: state encoding,
// default sizing and the power-up phase duration.
package tick_phase_sequencer_pkg;

   localparam int DEF_NUM_PHASES = 4;
   localparam int DEF_TICK_W     = 8;
   localparam int DEF_LEN        = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage : tick_phase_sequencer_pkg

// File: rtl/tick_phase_sequencer_phase_len_regfile.sv
// Per-phase duration table: one write port that drops out-of-range indices,
// one combinational read port, all entries reset to the default length.
module phase_len_regfile
   import tick_phase_sequencer_pkg::*;
#(
   parameter int NUM_PHASES = DEF_NUM_PHASES,
   parameter int TICK_W     = DEF_TICK_W,
   parameter int PH_W       = $clog2(NUM_PHASES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [PH_W-1:0]   wr_idx,
   input  logic [TICK_W-1:0] wr_data,
   input  logic [PH_W-1:0]   rd_idx,
   output logic [TICK_W-1:0] rd_data
);

   logic [TICK_W-1:0] len_q [NUM_PHASES];

   // NOTE: this table is built from flops, not RAM, so it can and must be
   // reset; a real RAM macro has no reset and would need an init sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PHASES; i++) begin
            len_q[i] <= TICK_W'(DEF_LEN);
         end
      end else if (wr_en && (int'(wr_idx) < NUM_PHASES)) begin
         // NOTE: state is updated with <= so every flop samples pre-edge
         // values; blocking = here would create ordering-dependent races.
         len_q[wr_idx] <= wr_data;
      end
   end

   assign rd_data = len_q[rd_idx];

endmodule : phase_len_regfile

// File: rtl/tick_phase_sequencer.sv
// Steps through a programmable list of phases, advancing on timebase ticks,
// and reports phase index, start-of-phase and end-of-sequence pulses.
module tick_phase_sequencer
   import tick_phase_sequencer_pkg::*;
#(
   parameter int NUM_PHASES = DEF_NUM_PHASES,
   parameter int TICK_W     = DEF_TICK_W,
   parameter int PH_W       = $clog2(NUM_PHASES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              loop_i,
   input  logic              tick_i,
   input  logic              cfg_valid_i,
   output logic              cfg_ready_o,
   input  logic [PH_W-1:0]   cfg_idx_i,
   input  logic [TICK_W-1:0] cfg_len_i,
   output logic [PH_W-1:0]   phase_o,
   output logic              phase_valid_o,
   output logic              phase_start_o,
   output logic              seq_done_o,
   output logic              busy_o
);

   localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NUM_PHASES - 1);

   state_e            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [TICK_W-1:0] count_q, count_d;
   logic              start_q, start_d;
   logic              done_q, done_d;

   logic [TICK_W-1:0] cur_len;
   logic [TICK_W-1:0] last_tick;
   logic              cfg_wr;

   assign cfg_wr = cfg_valid_i && (state_q == ST_IDLE);

   phase_len_regfile #(
      .NUM_PHASES (NUM_PHASES),
      .TICK_W     (TICK_W),
      .PH_W       (PH_W)
   ) u_len_table (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (cfg_wr),
      .wr_idx  (cfg_idx_i),
      .wr_data (cfg_len_i),
      .rd_idx  (phase_q),
      .rd_data (cur_len)
   );

   // A programmed length of zero behaves like a one-tick phase.
   assign last_tick = (cur_len == '0) ? '0 : cur_len - 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         count_q <= '0;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         count_q <= count_d;
         start_q <= start_d;
         done_q  <= done_d;
      end
   end

   // NOTE: every variable gets a default before the case so no path leaves
   // it unassigned; a missing default in always_comb infers a latch.
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      count_d = count_q;
      start_d = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_RUN;
               phase_d = '0;
               count_d = '0;
               start_d = 1'b1;
            end
         end
         ST_RUN: begin
            // Stop has priority; a tick arriving with it is discarded.
            if (stop_i) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else if (tick_i) begin
               if (count_q == last_tick) begin
                  count_d = '0;
                  if (phase_q != LAST_PHASE) begin
                     phase_d = phase_q + 1'b1;
                     start_d = 1'b1;
                  end else if (loop_i) begin
                     phase_d = '0;
                     start_d = 1'b1;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  count_d = count_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cfg_ready_o   = (state_q == ST_IDLE);
      busy_o        = (state_q == ST_RUN);
      phase_valid_o = (state_q == ST_RUN);
      phase_o       = phase_q;
      phase_start_o = start_q;
      seq_done_o    = done_q;
   end

endmodule : tick_phase_sequencer

// File: tb/tb_tick_phase_sequencer.sv
// Directed, table-driven bench for tick_phase_sequencer (4-phase instance)
// plus a 5-phase instance for the out-of-range config index case.
module tb_tick_phase_sequencer;

   localparam int NP = 4;
   localparam int TW = 8;
   localparam int PW = 2;

   logic clk = 1'b0;
   logic rst_n;
   logic start, stop, loop_en, tick;
   logic cfg_valid;
   logic [PW-1:0] cfg_idx;
   logic [TW-1:0] cfg_len;

   logic          cfg_ready, phase_valid, phase_start, seq_done, busy;
   logic [PW-1:0] phase;

   logic          cfg_valid5;
   logic [2:0]    cfg_idx5;
   logic          cfg_ready5, phase_valid5, phase_start5, seq_done5, busy5;
   logic [2:0]    phase5;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   tick_phase_sequencer #(.NUM_PHASES(NP), .TICK_W(TW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start),
      .stop_i        (stop),
      .loop_i        (loop_en),
      .tick_i        (tick),
      .cfg_valid_i   (cfg_valid),
      .cfg_ready_o   (cfg_ready),
      .cfg_idx_i     (cfg_idx),
      .cfg_len_i     (cfg_len),
      .phase_o       (phase),
      .phase_valid_o (phase_valid),
      .phase_start_o (phase_start),
      .seq_done_o    (seq_done),
      .busy_o        (busy)
   );

   tick_phase_sequencer #(.NUM_PHASES(5), .TICK_W(TW)) dut5 (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (start),
      .stop_i        (stop),
      .loop_i        (loop_en),
      .tick_i        (tick),
      .cfg_valid_i   (cfg_valid5),
      .cfg_ready_o   (cfg_ready5),
      .cfg_idx_i     (cfg_idx5),
      .cfg_len_i     (cfg_len),
      .phase_o       (phase5),
      .phase_valid_o (phase_valid5),
      .phase_start_o (phase_start5),
      .seq_done_o    (seq_done5),
      .busy_o        (busy5)
   );

   typedef struct {
      logic          start, stop, loop_en, tick, cfg_valid;
      logic [PW-1:0] cfg_idx;
      logic [TW-1:0] cfg_len;
      logic [PW-1:0] e_phase;
      logic          e_run, e_start, e_done;
   } vec_t;

   vec_t vq[$];

   // Expected outputs packed as {phase, valid, start, done, busy, ready}.
   function automatic vec_t mk(input logic st, sp, lp, tk, cv,
                               input logic [PW-1:0] ci, input logic [TW-1:0] cl,
                               input logic [PW-1:0] ep,
                               input logic er, es, ed);
      vec_t v;
      v.start = st; v.stop = sp; v.loop_en = lp; v.tick = tk; v.cfg_valid = cv;
      v.cfg_idx = ci; v.cfg_len = cl;
      v.e_phase = ep; v.e_run = er; v.e_start = es; v.e_done = ed;
      return v;
   endfunction

   function automatic logic [6:0] obs();
      return {phase, phase_valid, phase_start, seq_done, busy, cfg_ready};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      start = 0; stop = 0; loop_en = 0; tick = 0;
      cfg_valid = 0; cfg_idx = '0; cfg_len = '0;
      cfg_valid5 = 0; cfg_idx5 = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run_vecs(input string name);
      for (int i = 0; i < vq.size(); i++) begin
         start = vq[i].start; stop = vq[i].stop; loop_en = vq[i].loop_en;
         tick = vq[i].tick; cfg_valid = vq[i].cfg_valid;
         cfg_idx = vq[i].cfg_idx; cfg_len = vq[i].cfg_len;
         step();
         check($sformatf("%s[%0d]", name, i), 32'(obs()),
               32'({vq[i].e_phase, vq[i].e_run, vq[i].e_start, vq[i].e_done,
                    vq[i].e_run, ~vq[i].e_run}));
      end
      idle_inputs();
      vq.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1;
      idle_inputs();
      #3;

      // Reset state, then default 1-tick phases with a tick every 3rd cycle.
      do_reset();
      check("reset_outputs", 32'(obs()), 32'(7'b00_000_01));
      vq.push_back(mk(1,0,0,0,0,0,0, 0,1,1,0));
      vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0));
      vq.push_back(mk(0,0,0,0,0,0,0, 0,1,0,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 1,1,1,0));
      vq.push_back(mk(0,0,0,0,0,0,0, 1,1,0,0));
      vq.push_back(mk(0,0,0,0,0,0,0, 1,1,0,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 2,1,1,0));
      vq.push_back(mk(0,0,0,0,0,0,0, 2,1,0,0));
      vq.push_back(mk(0,0,0,0,0,0,0, 2,1,0,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 3,1,1,0));
      vq.push_back(mk(0,0,0,0,0,0,0, 3,1,0,0));
      vq.push_back(mk(0,0,0,0,0,0,0, 3,1,0,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 3,0,0,1));
      vq.push_back(mk(0,0,0,0,0,0,0, 3,0,0,0));
      vq.push_back(mk(0,1,0,1,0,0,0, 3,0,0,0));
      run_vecs("default_seq");

      // Table {2,0,3,1}; last entry written on the same edge as start.
      do_reset();
      vq.push_back(mk(0,0,0,0,1,0,2, 0,0,0,0));
      vq.push_back(mk(0,0,0,0,1,1,0, 0,0,0,0));
      vq.push_back(mk(0,0,0,0,1,2,3, 0,0,0,0));
      vq.push_back(mk(1,0,0,0,1,3,1, 0,1,1,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 0,1,0,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 1,1,1,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 2,1,1,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 2,1,0,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 2,1,0,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 3,1,1,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 3,0,0,1));
      vq.push_back(mk(0,0,0,0,0,0,0, 3,0,0,0));
      run_vecs("prog_seq");

      // Looping for 10 ticks, then stop together with a tick in phase 2.
      do_reset();
      vq.push_back(mk(1,0,1,0,0,0,0, 0,1,1,0));
      for (int i = 0; i < 10; i++)
         vq.push_back(mk(0,0,1,1,0,0,0, PW'((i + 1) % NP), 1,1,0));
      vq.push_back(mk(0,1,0,1,0,0,0, 2,0,0,0));
      vq.push_back(mk(0,0,0,0,0,0,0, 2,0,0,0));
      run_vecs("loop_stop");

      // Config while busy is dropped: phase 0 still lasts one tick.
      do_reset();
      vq.push_back(mk(1,0,0,0,0,0,0, 0,1,1,0));
      vq.push_back(mk(0,0,0,0,1,0,5, 0,1,0,0));
      vq.push_back(mk(0,1,0,0,0,0,0, 0,0,0,0));
      vq.push_back(mk(1,0,0,0,0,0,0, 0,1,1,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 1,1,1,0));
      vq.push_back(mk(0,1,0,0,0,0,0, 1,0,0,0));
      run_vecs("busy_cfg");

      // Out-of-range index on the 5-phase instance: all phases stay 1 tick.
      do_reset();
      cfg_valid5 = 1; cfg_idx5 = 3'd5; cfg_len = 8'd3;
      step();
      cfg_valid5 = 0; cfg_len = '0;
      check("oor_idle", 32'({busy5, cfg_ready5}), 32'(2'b01));
      start = 1;
      step();
      start = 0;
      check("oor_start", 32'({phase5, phase_start5, busy5}), 32'({3'd0, 1'b1, 1'b1}));
      for (int k = 1; k <= 4; k++) begin
         tick = 1;
         step();
         check($sformatf("oor_phase%0d", k), 32'({phase5, phase_start5, busy5}),
               32'({3'(k), 1'b1, 1'b1}));
      end
      step();
      tick = 0;
      check("oor_done", 32'({phase5, seq_done5, busy5}), 32'({3'd4, 1'b1, 1'b0}));
      idle_inputs();

      // Asynchronous reset mid phase 1 clears outputs and table.
      do_reset();
      vq.push_back(mk(0,0,0,0,1,0,2, 0,0,0,0));
      vq.push_back(mk(0,0,0,0,1,1,3, 0,0,0,0));
      vq.push_back(mk(1,0,0,0,0,0,0, 0,1,1,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 0,1,0,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 1,1,1,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 1,1,0,0));
      run_vecs("pre_areset");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 32'(obs()), 32'(7'b00_000_01));
      #2;
      rst_n = 1'b1;
      vq.push_back(mk(1,0,0,0,0,0,0, 0,1,1,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 1,1,1,0));
      vq.push_back(mk(0,0,0,1,0,0,0, 2,1,1,0));
      run_vecs("post_areset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_tick_phase_sequencer
